// File: rtl/regfile_writeback_if.sv
// Bundle of the ALU-result, load-return, hazard-query and register-file write
// signals. The producer side of the pipeline uses master; the controller uses slave.
interface regfile_writeback_if;
  logic        aluValid;
  logic [4:0]  aluReg;
  logic [31:0] aluData;
  logic        ldIssue;
  logic [4:0]  ldIssueReg;
  logic        ldValid;
  logic        ldReady;
  logic [4:0]  ldReg;
  logic [31:0] ldData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic        hazard1;
  logic        hazard2;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  modport master (
    output aluValid, aluReg, aluData,
    output ldIssue, ldIssueReg,
    output ldValid, ldReg, ldData,
    output readReg1, readReg2,
    input  ldReady, hazard1, hazard2,
    input  regWrite, writeReg, writeData
  );

  modport slave (
    input  aluValid, aluReg, aluData,
    input  ldIssue, ldIssueReg,
    input  ldValid, ldReg, ldData,
    input  readReg1, readReg2,
    output ldReady, hazard1, hazard2,
    output regWrite, writeReg, writeData
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: ALU results win, load returns queue in a
// small FIFO, and a per-register scoreboard flags sources still awaiting a load.
module regfile_writeback #(
  parameter int DEPTH = 2
) (
  input logic                 clock,
  input logic                 reset,
  regfile_writeback_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   fifo_data_q [DEPTH];
  logic [4:0]    fifo_reg_q  [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pending_q, pending_d;
  logic          reg_write_q, reg_write_d;
  logic [4:0]    write_reg_q, write_reg_d;
  logic [31:0]   write_data_q, write_data_d;

  logic          alu_wr_s;
  logic          ld_ready_s;
  logic          accept_s;
  logic          enq_s;
  logic          pop_s;
  logic [4:0]    head_reg_s;
  logic [31:0]   head_data_s;

  // Ready depends only on registered occupancy so it never loops back through ldValid.
  always_comb begin
    ld_ready_s  = (count_q != FULL_CNT);
    alu_wr_s    = bus.aluValid && (bus.aluReg != 5'd0);
    accept_s    = bus.ldValid && ld_ready_s;
    enq_s       = accept_s && (bus.ldReg != 5'd0);
    pop_s       = !alu_wr_s && (count_q != {CW{1'b0}});
    head_reg_s  = fifo_reg_q[rptr_q];
    head_data_s = fifo_data_q[rptr_q];
  end

  // Write-port arbitration and FIFO pointer/occupancy next state.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;

    if (alu_wr_s) begin
      reg_write_d  = 1'b1;
      write_reg_d  = bus.aluReg;
      write_data_d = bus.aluData;
    end else if (pop_s) begin
      reg_write_d  = 1'b1;
      write_reg_d  = head_reg_s;
      write_data_d = head_data_s;
    end else begin
      reg_write_d  = 1'b0;
    end

    if (enq_s) begin
      wptr_d = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end

    case ({enq_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Scoreboard: a pop clears its register, a new issue sets it; set is applied last so it wins.
  always_comb begin
    pending_d = pending_q;
    if (pop_s) begin
      pending_d[head_reg_s] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (bus.ldIssue && (bus.ldIssueReg != 5'd0)) begin
      pending_d[bus.ldIssueReg] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  // Control, scoreboard and write-port registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q       <= {AW{1'b0}};
      rptr_q       <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      pending_q    <= 32'd0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // FIFO storage; occupancy gates every read, so the payload needs no reset.
  always_ff @(posedge clock) begin
    if (!reset && enq_s) begin
      fifo_reg_q[wptr_q]  <= bus.ldReg;
      fifo_data_q[wptr_q] <= bus.ldData;
    end
  end

  assign bus.ldReady   = ld_ready_s;
  assign bus.hazard1   = pending_q[bus.readReg1];
  assign bus.hazard2   = pending_q[bus.readReg2];
  assign bus.regWrite  = reg_write_q;
  assign bus.writeReg  = write_reg_q;
  assign bus.writeData = write_data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized bench for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;

  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  ent_t        m_q[$];
  logic [31:0] m_pend;
  logic        m_wr;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;

  regfile_writeback_if bus ();

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input logic rst, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic iv, input logic [4:0] ir,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit   ready;
    ent_t e;
    reset          = rst;
    bus.aluValid   = av;
    bus.aluReg     = ar;
    bus.aluData    = ad;
    bus.ldIssue    = iv;
    bus.ldIssueReg = ir;
    bus.ldValid    = lv;
    bus.ldReg      = lr;
    bus.ldData     = ld;
    bus.readReg1   = r1;
    bus.readReg2   = r2;
    #2;
    ready = (m_q.size() != DEPTH);
    chk("ldReady", 32'(bus.ldReady), 32'(ready));
    chk("hazard1", 32'(bus.hazard1), 32'(m_pend[r1]));
    chk("hazard2", 32'(bus.hazard2), 32'(m_pend[r2]));
    @(posedge clock);
    if (rst) begin
      m_q.delete();
      m_pend  = 32'd0;
      m_wr    = 1'b0;
      m_wreg  = 5'd0;
      m_wdata = 32'd0;
    end else begin
      if (av && ar != 5'd0) begin
        m_wr = 1'b1; m_wreg = ar; m_wdata = ad;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_wr = 1'b1; m_wreg = e.r; m_wdata = e.d;
        m_pend[e.r] = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
      if (lv && ready && lr != 5'd0) begin
        e.r = lr; e.d = ld;
        m_q.push_back(e);
      end
      if (iv && ir != 5'd0) m_pend[ir] = 1'b1;
      m_pend[0] = 1'b0;
    end
    #1;
    chk("regWrite", 32'(bus.regWrite), 32'(m_wr));
    if (m_wr || rst) begin
      chk("writeReg", 32'(bus.writeReg), 32'(m_wreg));
      chk("writeData", bus.writeData, m_wdata);
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  initial begin
    m_pend = 32'd0; m_wr = 1'b0; m_wreg = 5'd0; m_wdata = 32'd0;
    reset = 1'b1;
    bus.aluValid = 1'b0; bus.aluReg = 5'd0; bus.aluData = 32'd0;
    bus.ldIssue = 1'b0; bus.ldIssueReg = 5'd0;
    bus.ldValid = 1'b0; bus.ldReg = 5'd0; bus.ldData = 32'd0;
    bus.readReg1 = 5'd0; bus.readReg2 = 5'd0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state and idle behaviour
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd31);
    chk("rst_writeReg", 32'(bus.writeReg), 32'd0);
    chk("rst_writeData", bus.writeData, 32'd0);
    idle(5'd0, 5'd17);
    idle(5'd9, 5'd8);

    // ALU write to r8, then a discarded write to r0
    step(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("alu_data", bus.writeData, 32'hDEADBEEF);
    idle(5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd0, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Load to r9: issue, wait, return, write two cycles after accept
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 5'd9, 5'd1);
    repeat (3) idle(5'd9, 5'd1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h12345678, 5'd9, 5'd1);
    chk("ld_not_yet", 32'(bus.regWrite), 32'd0);
    idle(5'd9, 5'd1);
    chk("ld_data", bus.writeData, 32'h12345678);
    idle(5'd9, 5'd1);

    // ALU stream to r1..r4 while loads to r10/r11 return; third return meets a full FIFO
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11);
    step(1'b0, 1'b1, 5'd1, 32'h00000001, 1'b0, 5'd0, 1'b1, 5'd10, 32'hA0A0A0A0, 5'd10, 5'd11);
    step(1'b0, 1'b1, 5'd2, 32'h00000002, 1'b0, 5'd0, 1'b1, 5'd11, 32'hB1B1B1B1, 5'd10, 5'd11);
    step(1'b0, 1'b1, 5'd3, 32'h00000003, 1'b0, 5'd0, 1'b1, 5'd13, 32'hC3C3C3C3, 5'd10, 5'd11);
    chk("full_ready", 32'(bus.ldReady), 32'd0);
    step(1'b0, 1'b1, 5'd4, 32'h00000004, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11);
    idle(5'd10, 5'd11);
    chk("order_first", 32'(bus.writeReg), 32'd10);
    idle(5'd10, 5'd11);
    chk("order_second", 32'(bus.writeReg), 32'd11);
    idle(5'd10, 5'd11);

    // Re-issue r12 in the cycle its older load pops: pending stays set
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd12, 32'h5555AAAA, 5'd12, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    idle(5'd12, 5'd12);
    chk("set_wins", 32'(bus.hazard1), 32'd1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd12, 32'h77778888, 5'd12, 5'd0);
    idle(5'd12, 5'd0);
    idle(5'd12, 5'd0);

    // Reset with two queued entries and pending bits
    step(1'b0, 1'b1, 5'd5, 32'h5, 1'b1, 5'd20, 1'b0, 5'd0, 32'd0, 5'd20, 5'd21);
    step(1'b0, 1'b1, 5'd6, 32'h6, 1'b1, 5'd21, 1'b1, 5'd20, 32'h20, 5'd20, 5'd21);
    step(1'b0, 1'b1, 5'd7, 32'h7, 1'b0, 5'd0, 1'b1, 5'd21, 32'h21, 5'd20, 5'd21);
    step(1'b1, 1'b1, 5'd7, 32'h7, 1'b0, 5'd0, 1'b1, 5'd22, 32'h22, 5'd20, 5'd21);
    chk("rst_ready", 32'(bus.ldReady), 32'd1);
    repeat (3) idle(5'd20, 5'd21);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] ir;
      logic       iv;
      ir = 5'($urandom_range(1, 31));
      iv = ($urandom_range(0, 3) == 0) && !m_pend[ir];
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom,
           iv, ir,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
